// File: rtl/iter_muldiv.sv
// Iterative unsigned multiply/divide unit, one bit per cycle.
// Shift-add multiply and restoring divide share one 2*WIDTH accumulator.
module iter_muldiv #(
    parameter int WIDTH = 32,
    parameter int CW    = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opb;
    logic [CW-1:0]      r_cnt;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_result;

    logic               w_last;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [2*WIDTH:0]   w_div_sh;
    logic [WIDTH:0]     w_div_trial;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0]   w_res;

    assign w_last = (r_cnt == CW'(WIDTH - 1));

    // Multiply step: conditional add into the high half, then shift right
    // with the carry entering the top bit.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + (r_acc[0] ? {1'b0, r_opb} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide step: shift left keeping the bit that leaves the top, so the
    // partial remainder is compared at WIDTH+1 bits.
    assign w_div_sh    = {r_acc, 1'b0};
    assign w_div_trial = w_div_sh[2*WIDTH:WIDTH] - {1'b0, r_opb};
    assign w_div_next  = w_div_trial[WIDTH]
                       ? w_div_sh[2*WIDTH-1:0]
                       : {w_div_trial[WIDTH-1:0],
                          w_div_sh[WIDTH-1:1], 1'b1};

    assign w_acc_next = r_op[1] ? w_div_next : w_mul_next;
    assign w_res      = r_op[0] ? w_acc_next[2*WIDTH-1:WIDTH]
                                : w_acc_next[WIDTH-1:0];

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Operand capture, iteration, and result write on the final step.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_acc    <= '0;
            r_opb    <= '0;
            r_cnt    <= '0;
            r_op     <= '0;
            r_result <= '0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_acc <= {{WIDTH{1'b0}}, operand_a};
                r_opb <= operand_b;
                r_op  <= op;
                r_cnt <= '0;
            end else if (r_state == S_RUN) begin
                r_acc <= w_acc_next;
                r_cnt <= r_cnt + 1'b1;
                if (w_last) r_result <= w_res;
            end
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE);
    assign result = r_result;

endmodule

// File: tb/tb_iter_muldiv.sv
// Directed bench for iter_muldiv with a result scoreboard queue.
// Checks latency, busy length, results, ignored start and async reset.
module tb_iter_muldiv;

    localparam int W = 32;

    logic         clock;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] sb_q[$];

    iter_muldiv #(.WIDTH(W), .CW(6)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one request and return right after the accept edge.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        @(negedge clock);
        start     = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        @(posedge clock);
        #1;
        start     = 1'b0;
    endtask

    // Wait for done; optionally pulse start (with a=b=1) at cycle pulse_at.
    task automatic collect(input string tag, input int pulse_at);
        int lat;
        int bcnt;
        logic [W-1:0] exp;
        lat  = 0;
        bcnt = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clock);
            if (n == pulse_at) begin
                start     = 1'b1;
                op        = 2'b00;
                operand_a = 32'd1;
                operand_b = 32'd1;
            end else begin
                start = 1'b0;
            end
            if (busy) bcnt++;
            if (done) begin
                lat = n;
                break;
            end
        end
        start = 1'b0;
        chk({tag, "_latency"}, W'(lat), W'(33));
        chk({tag, "_busy_cycles"}, W'(bcnt), W'(33));
        if (sb_q.size() == 0) exp = 'x;
        else exp = sb_q.pop_front();
        chk({tag, "_result"}, result, exp);
        @(negedge clock);
        chk({tag, "_done_one_cycle"}, W'(done), W'(0));
        chk({tag, "_result_held"}, result, exp);
    endtask

    // Count done pulses over a window where none are expected.
    task automatic no_done(input string tag, input int cycles);
        int pulses;
        pulses = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clock);
            if (done) pulses++;
        end
        chk({tag, "_no_done"}, W'(pulses), W'(0));
    endtask

    task automatic run(input string tag, input logic [1:0] o,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp);
        sb_q.push_back(exp);
        issue(o, a, b);
        collect(tag, 0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        op        = 2'b00;
        operand_a = '0;
        operand_b = '0;
        repeat (3) @(negedge clock);
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_result", result, '0);
        reset = 1'b0;

        run("mul_lo_7x6", 2'b00, 32'd7, 32'd6, 32'd42);
        run("mul_hi_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run("mul_lo_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        run("div_q_100_7", 2'b10, 32'd100, 32'd7, 32'd14);
        run("div_r_100_7", 2'b11, 32'd100, 32'd7, 32'd2);
        run("div_q_msb", 2'b10, 32'h8000_0000, 32'd1, 32'h8000_0000);
        run("div0_q", 2'b10, 32'h1234, 32'd0, 32'hFFFF_FFFF);
        run("div0_r", 2'b11, 32'h1234, 32'd0, 32'h1234);

        sb_q.push_back(32'd14);
        issue(2'b10, 32'd100, 32'd7);
        collect("busy_start", 5);
        no_done("busy_start", 40);
        chk("busy_start_result", result, 32'd14);

        issue(2'b00, 32'hDEAD, 32'hBEEF);
        repeat (10) @(negedge clock);
        reset = 1'b1;
        #1;
        chk("midrst_busy", W'(busy), W'(0));
        chk("midrst_done", W'(done), W'(0));
        chk("midrst_result", result, '0);
        @(negedge clock);
        reset = 1'b0;
        no_done("midrst", 40);
        chk("midrst_idle", W'(busy), W'(0));

        run("mul_3x5", 2'b00, 32'd3, 32'd5, 32'd15);

        chk("sb_empty", W'(sb_q.size()), W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
